sar_adc_digital_core: RTL and testbench
=======================================

// Module: sar_adc_digital_core
// PURPOSE
//  Digital/RNM core of a successive-approximation ADC.
//  - Generates the sample strobe for the external sample-and-hold.
//  - Runs the binary search from the external comparator decision.
//  - Drives the feedback DAC voltage (SV real) back to that comparator.
//  - Sits between the S&H/comparator models and the ADC top-level interface.
// PARAMETERS
//  NUM_BITS  4     resolution; width of d_out and of the SAR register
//  V_SCALE   16.0  DAC full-scale (real, volts); LSB = V_SCALE/2**NUM_BITS (1.0 V at defaults)
// PORTS
//  clk          in   1         single clock; all state updates on posedge
//  rst          in   1         asynchronous, active-high reset
//  sample_rate  in   2         conversion period: 00=5, 01=10, 10=15, 11=20 clk cycles
//  cmp_out      in   1         comparator: 1 = Vin(held) > dac_out
//  sample       out  1         1-cycle strobe; S&H captures Vin on its rising edge
//  d_out        out  NUM_BITS  SAR register; final code when eoc=1
//  eoc          out  1         end-of-conversion, 1-cycle pulse
//  dac_out      out  real      d_out * V_SCALE / 2**NUM_BITS, combinational
// BEHAVIOUR
//  Reset (rst=1, async): sample=0, eoc=0, d_out=1000..0 (MSB only, 4'b1000), dac_out=8.0 V.
//   - Period counter and bit counter go to 0.
//   - Reset mid-conversion aborts the conversion. No eoc is produced for it.
//  Controller:
//   - Period counter runs 0..P-1, with P = 5*(sample_rate+1).
//   - sample=1 for exactly the cycle in which the counter is 0.
//   - The first strobe occurs on the first posedge after rst is released.
//   - sample_rate is latched at each strobe. A change mid-period takes effect at the next period.
//  SAR, cycle-level (T0 = edge that raises sample):
//   - T0: d_out <= MSB-only trial code; bit index <= NUM_BITS-1; bit counter <= 0; eoc <= 0.
//   - T1..T(NUM_BITS): at edge Tk, sample cmp_out for the current trial bit.
//     - cmp_out=1: keep the bit. cmp_out=0: clear it.
//     - If a lower bit remains, set it as the next trial bit.
//     - Increment the bit counter.
//   - The edge that brings the bit counter to NUM_BITS also sets eoc=1.
//     This is T4 at defaults, i.e. eoc rises 4 cycles after the strobe.
//   - Next edge: eoc=0. d_out holds the final code until the next strobe.
//   - cmp_out is ignored outside T1..T(NUM_BITS).
//  Result:
//   - d_out = floor(Vin/LSB), clamped to 0..2**NUM_BITS-1.
//   - Vin outside 0..V_SCALE gives all-zeros or all-ones.
//   - Exact LSB boundaries resolve downward, because the comparator is strict '>'.
//  Sampling vs conversion:
//   - Conversion always fits in the shortest period (1 + NUM_BITS <= 5).
//   - For NUM_BITS > 4, P scales as (NUM_BITS+1)*(sample_rate+1).
//  A strobe arriving while a conversion is in progress (only possible after a reset glitch) restarts the SAR.
//  dac_out tracks d_out with zero delay. It is real-valued; no X/Z propagation is required.
// STRUCTURE
//  - Package sar_adc_pkg:
//    - NUM_BITS/V_SCALE defaults.
//    - sample_rate_e enum (SR_5, SR_10, SR_15, SR_20).
//    - function period_cycles(sample_rate_e).
//    - function code2volt(code) returning real.
//  - Sub-module sar_rate_ctrl: period counter + sample strobe.
//  - SAR register and DAC expression stay in the top module.
// TESTING
//  - Reset: rst=1 mid-conversion -> immediately d_out=4'b1000, eoc=0, sample=0, dac_out=8.0.
//  - sample_rate=00, Vin=5.3 (bench comparator model) -> eoc pulses 4 clk after sample, d_out=4'b0101.
//    Trial sequence 1000 -> 0100 -> 0110 -> 0101.
//  - Vin=15.9 -> 4'b1111; Vin=0.2 -> 4'b0000; Vin=20.0 -> 4'b1111 (clamp).
//  - sample_rate 00/01/10/11 -> sample strobes exactly 5/10/15/20 cycles apart.
//    Exactly one eoc per period.
//  - sample_rate changed 00->11 mid-period -> current period stays 5 cycles; the following ones are 20.
//  - Every eoc: d_out == floor(Vin_at_sample/1.0).
//    Assertions check eoc rises exactly 4 cycles after sample, and that dac_out == d_out*1.0.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// Shared defaults, sample-rate encoding and helper functions
// for the SAR ADC digital core.
package sar_adc_pkg;

   localparam int  NUM_BITS_DEF = 4;
   localparam real V_SCALE_DEF  = 16.0;

   typedef enum logic [1:0] {
      SR_5  = 2'b00,
      SR_10 = 2'b01,
      SR_15 = 2'b10,
      SR_20 = 2'b11
   } sample_rate_e;

   // Base period must hold one sample cycle plus one cycle per bit.
   function automatic int period_cycles(sample_rate_e sr, int nb);
      int base;
      base = (nb > 4) ? nb + 1 : 5;
      return base * (int'(sr) + 1);
   endfunction

   function automatic real code2volt(int unsigned code, int nb, real vs);
      return real'(code) * vs / real'(2 ** nb);
   endfunction

endpackage

// File: rtl/sar_adc_digital_core_rate_ctrl.sv
// Conversion period counter and sample strobe generator.
// start is high in the cycle before each strobe edge.
module sar_rate_ctrl
   import sar_adc_pkg::*;
#(
   parameter int NUM_BITS = NUM_BITS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] sample_rate,
   output logic       sample,
   output logic       start
);

   localparam int PMAX = period_cycles(SR_20, NUM_BITS);
   localparam int PW   = $clog2(PMAX + 1);

   logic [PW-1:0] cnt;
   logic [PW-1:0] period;
   logic          run;

   // First edge after reset always strobes; afterwards on wrap.
   assign start = !run || (cnt == period - 1'b1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         period <= PW'(period_cycles(SR_5, NUM_BITS));
         run    <= 1'b0;
         sample <= 1'b0;
      end else begin
         run    <= 1'b1;
         sample <= start;
         if (start) begin
            cnt    <= '0;
            period <= PW'(period_cycles(sample_rate_e'(sample_rate),
                                        NUM_BITS));
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sar_adc_digital_core.sv
// SAR ADC digital core: binary-search register, feedback DAC value
// and end-of-conversion pulse, paced by sar_rate_ctrl.
module sar_adc_digital_core
   import sar_adc_pkg::*;
#(
   parameter int  NUM_BITS = NUM_BITS_DEF,
   parameter real V_SCALE  = V_SCALE_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          sample_rate,
   input  logic                cmp_out,
   output logic                sample,
   output logic [NUM_BITS-1:0] d_out,
   output logic                eoc,
   output real                 dac_out
);

   localparam int IW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
   localparam int CW = $clog2(NUM_BITS + 1);
   localparam logic [NUM_BITS-1:0] MSB = NUM_BITS'(1) << (NUM_BITS - 1);

   logic                start;
   logic                busy;
   logic [IW-1:0]       idx;
   logic [CW-1:0]       bcnt;
   logic [NUM_BITS-1:0] trial;
   logic                last;

   sar_rate_ctrl #(
      .NUM_BITS (NUM_BITS)
   ) u_rate (
      .clk         (clk),
      .rst         (rst),
      .sample_rate (sample_rate),
      .sample      (sample),
      .start       (start)
   );

   // Resolve the current bit from the comparator, then arm the next one.
   always_comb begin
      trial      = d_out;
      trial[idx] = cmp_out;
      if (idx != '0) begin
         trial[idx - 1'b1] = 1'b1;
      end
   end

   assign last = (bcnt == CW'(NUM_BITS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_out <= MSB;
         idx   <= '0;
         bcnt  <= '0;
         eoc   <= 1'b0;
         busy  <= 1'b0;
      end else if (start) begin
         d_out <= MSB;
         idx   <= IW'(NUM_BITS - 1);
         bcnt  <= '0;
         eoc   <= 1'b0;
         busy  <= 1'b1;
      end else if (busy) begin
         d_out <= trial;
         if (idx != '0) begin
            idx <= idx - 1'b1;
         end
         bcnt <= bcnt + 1'b1;
         eoc  <= last;
         busy <= !last;
      end else begin
         eoc <= 1'b0;
      end
   end

   assign dac_out = code2volt(32'(d_out), NUM_BITS, V_SCALE);

endmodule

// File: tb/tb_sar_adc_digital_core.sv
// Self-checking bench for sar_adc_digital_core with a comparator
// model, a scoreboard of expected codes and table-driven vectors.
module tb_sar_adc_digital_core;

   logic       clk;
   logic       rst;
   logic [1:0] sample_rate;
   logic       cmp_out;
   logic       sample;
   logic [3:0] d_out;
   logic       eoc;
   real        dac_out;

   real vin;
   real vin_held;

   int total = 0;
   int bad   = 0;

   sar_adc_digital_core dut (
      .clk         (clk),
      .rst         (rst),
      .sample_rate (sample_rate),
      .cmp_out     (cmp_out),
      .sample      (sample),
      .d_out       (d_out),
      .eoc         (eoc),
      .dac_out     (dac_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge sample) vin_held = vin;
   assign cmp_out = (vin_held > dac_out);

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   // Strict '>' comparator: exact LSB boundaries resolve one code down.
   function automatic int model(input real v);
      int c;
      c = int'($ceil(v)) - 1;
      if (v <= 0.0) c = 0;
      if (c < 0) c = 0;
      if (c > 15) c = 15;
      return c;
   endfunction

   int exp_q[$];
   int since_s = 0;
   int gap_cnt = 0;
   int last_gap = 0;
   int prev_sr = 0;
   int eocs = 0;
   bit have_prev = 0;

   always @(posedge clk) begin
      #1;
      if (rst) begin
         have_prev = 0;
         exp_q.delete();
      end else begin
         gap_cnt++;
         since_s++;
         chk("dac_track", int'(dac_out * 1000.0), 1000 * int'(d_out));
         if (sample) begin
            if (have_prev) begin
               chk("period", gap_cnt, 5 * (prev_sr + 1));
               chk("eoc_per_period", eocs, 1);
               last_gap = gap_cnt;
            end
            have_prev = 1;
            gap_cnt   = 0;
            since_s   = 0;
            eocs      = 0;
            prev_sr   = int'(sample_rate);
            exp_q.push_back(model(vin_held));
         end
         if (eoc) begin
            eocs++;
            chk("eoc_delay", since_s, 4);
            if (exp_q.size() == 0) begin
               chk("eoc_unexpected", 1, 0);
            end else begin
               chk("scoreboard", int'(d_out), exp_q.pop_front());
            end
         end
      end
   end

   task automatic wait_strobe();
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #2;
         if (sample) return;
      end
      chk("strobe_timeout", 0, 1);
   endtask

   task automatic wait_eoc();
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #2;
         if (eoc) return;
      end
      chk("eoc_timeout", 0, 1);
   endtask

   typedef struct {
      logic [1:0] sr;
      real        v;
      int         code;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{2'd0, 5.3, 5};
      vecs[1] = '{2'd0, 15.9, 15};
      vecs[2] = '{2'd0, 0.2, 0};
      vecs[3] = '{2'd0, 20.0, 15};
      vecs[4] = '{2'd1, 7.7, 7};
      vecs[5] = '{2'd2, 11.1, 11};
      vecs[6] = '{2'd3, 3.5, 3};
      vecs[7] = '{2'd0, 5.0, 4};
      vecs[8] = '{2'd1, -2.0, 0};
      vecs[9] = '{2'd0, 12.0, 11};

      rst         = 1'b1;
      sample_rate = 2'd0;
      vin         = 5.3;
      vin_held    = 0.0;
      #12;
      chk("rst_d_out", int'(d_out), 8);
      chk("rst_eoc", int'(eoc), 0);
      chk("rst_sample", int'(sample), 0);
      chk("rst_dac", int'(dac_out * 1000.0), 8000);

      // First strobe and the 5.3 V trial sequence.
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #2;
      chk("first_strobe", int'(sample), 1);
      chk("trial0", int'(d_out), 4'b1000);
      @(posedge clk);
      #2;
      chk("trial1", int'(d_out), 4'b0100);
      @(posedge clk);
      #2;
      chk("trial2", int'(d_out), 4'b0110);
      @(posedge clk);
      #2;
      chk("trial3", int'(d_out), 4'b0101);
      @(posedge clk);
      #2;
      chk("eoc_t4", int'(eoc), 1);
      chk("code_5v3", int'(d_out), 4'b0101);
      @(posedge clk);
      #2;
      chk("eoc_drop", int'(eoc), 0);

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         sample_rate = vecs[i].sr;
         vin         = vecs[i].v;
         wait_eoc();
         chk("vec_code", int'(d_out), vecs[i].code);
      end

      // Rate change mid-period only affects the following period.
      wait_strobe();
      @(negedge clk);
      @(negedge clk);
      sample_rate = 2'd3;
      wait_strobe();
      chk("gap_keep5", last_gap, 5);
      wait_strobe();
      chk("gap_now20", last_gap, 20);

      // Asynchronous reset in the middle of a conversion.
      @(negedge clk);
      sample_rate = 2'd0;
      wait_strobe();
      @(negedge clk);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_d_out", int'(d_out), 8);
      chk("mid_rst_eoc", int'(eoc), 0);
      chk("mid_rst_sample", int'(sample), 0);
      chk("mid_rst_dac", int'(dac_out * 1000.0), 8000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #2;
      chk("restart_strobe", int'(sample), 1);
      wait_eoc();
      chk("restart_code", int'(d_out), 11);

      repeat (12) @(posedge clk);
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
